program_counter_stack: RTL

// - Next-generation program counter for the 8-bit CPU core: parametrised address width plus a hardware return-address stack.
// - Supports increment, jump (load from bus), call (push + jump) and return (pop).
// - Drives its value onto the shared bus on request and reports stack status/errors to the control block.
// - Sits between the control block (command strobes) and the shared data/address bus.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/lifo_stack.sv | 59 +++++
 rtl/program_counter_stack.sv | 100 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU core program counter.
// Holds default widths, the reset vector default and the command encoding,
// whose numeric order is the command priority (larger value wins).
package cpu_pkg;

  localparam int unsigned DEF_ADDR_W    = 4;
  localparam int unsigned DEF_DEPTH     = 4;
  localparam int unsigned DEF_RESET_VEC = 0;

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_INC  = 3'd1,
    CMD_LOAD = 3'd2,
    CMD_RET  = 3'd3,
    CMD_CALL = 3'd4
  } cmd_e;

  // Collapse the strobes to one command: call > ret > load > inc.
  function automatic cmd_e decode_cmd(input logic call_en, input logic ret_en,
                                      input logic load_en, input logic inc_en);
    cmd_e cmd;
    if (call_en)      cmd = CMD_CALL;
    else if (ret_en)  cmd = CMD_RET;
    else if (load_en) cmd = CMD_LOAD;
    else if (inc_en)  cmd = CMD_INC;
    else              cmd = CMD_NONE;
    return cmd;
  endfunction

endpackage

// File: rtl/lifo_stack.sv
// Small register-based LIFO used as the return-address stack.
// Ports:
//   clk, rst   clock and synchronous active-high reset (empties the stack)
//   push, din  write din on top of the stack (ignored when full)
//   pop        drop the top entry (ignored when empty)
//   dout       current top-of-stack value (don't-care when empty)
//   count      number of occupied entries
//   full       count == DEPTH
//   empty      count == 0
module lifo_stack #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  // Storage is rounded up to a power of two so any index value is in range.
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [2**IdxW];
  logic [CntW-1:0]  count_q, count_d;
  logic [IdxW-1:0]  wr_idx, rd_idx;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wr_idx  = IdxW'(count_q);
  assign rd_idx  = IdxW'(count_q - CntW'(1));
  assign dout    = mem_q[rd_idx];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push)     count_d = count_q + CntW'(1);
    else if (do_pop) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Contents need no reset; only count defines what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with hardware return-address stack for the 8-bit CPU core.
// Supports increment, jump, call (push + jump) and return (pop), drives the
// PC onto the shared bus on request and reports stack status and errors.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus_in     jump/call target from the bus
//   inc_en, load_en, call_en, ret_en   command strobes (call > ret > load > inc)
//   out_en     request to drive the PC onto the bus
//   pc_out     registered PC
//   bus_oe     combinational copy of out_en
//   sp         occupied stack entries; stk_full/stk_empty decode it
//   err_ovf    sticky: call attempted while full
//   err_unf    sticky: return attempted while empty
module program_counter_stack
  import cpu_pkg::*;
#(
  parameter int unsigned        ADDR_W    = DEF_ADDR_W,
  parameter int unsigned        DEPTH     = DEF_DEPTH,
  parameter logic [ADDR_W-1:0]  RESET_VEC = ADDR_W'(DEF_RESET_VEC)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           bus_in,
  input  logic                        inc_en,
  input  logic                        load_en,
  input  logic                        call_en,
  input  logic                        ret_en,
  input  logic                        out_en,
  output logic [ADDR_W-1:0]           pc_out,
  output logic                        bus_oe,
  output logic [$clog2(DEPTH+1)-1:0]  sp,
  output logic                        stk_full,
  output logic                        stk_empty,
  output logic                        err_ovf,
  output logic                        err_unf
);

  cmd_e              cmd;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ret_addr;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push, pop;

  lifo_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_q),
    .dout  (ret_addr),
    .count (sp),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign cmd  = decode_cmd(call_en, ret_en, load_en, inc_en);
  assign push = (cmd == CMD_CALL) && !stk_full;
  assign pop  = (cmd == CMD_RET) && !stk_empty;

  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    case (cmd)
      CMD_CALL: begin
        if (stk_full) ovf_d = 1'b1;
        else          pc_d  = bus_in;
      end
      CMD_RET: begin
        if (stk_empty) unf_d = 1'b1;
        else           pc_d  = ret_addr;
      end
      CMD_LOAD: pc_d = bus_in;
      CMD_INC:  pc_d = pc_q + ADDR_W'(1);
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc_out  = pc_q;
  assign bus_oe  = out_en;
  assign err_ovf = ovf_q;
  assign err_unf = unf_q;

endmodule
